// File: rtl/accel_spi_pkg.sv
// Shared constants, FSM state and sample bundle for the
// accelerometer SPI responder.
package accel_spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  localparam logic [7:0] DEVID_AD  = 8'hAD;
  localparam logic [7:0] DEVID_MST = 8'h1D;
  localparam logic [7:0] PARTID    = 8'hF2;

  localparam logic [5:0] A_DEVID_AD  = 6'h00;
  localparam logic [5:0] A_DEVID_MST = 6'h01;
  localparam logic [5:0] A_PARTID    = 6'h02;
  localparam logic [5:0] A_XDATA     = 6'h08;
  localparam logic [5:0] A_YDATA     = 6'h09;
  localparam logic [5:0] A_ZDATA     = 6'h0A;
  localparam logic [5:0] A_STATUS    = 6'h0B;
  localparam logic [5:0] A_XL        = 6'h0E;
  localparam logic [5:0] A_XH        = 6'h0F;
  localparam logic [5:0] A_YL        = 6'h10;
  localparam logic [5:0] A_YH        = 6'h11;
  localparam logic [5:0] A_ZL        = 6'h12;
  localparam logic [5:0] A_ZH        = 6'h13;
  localparam logic [5:0] A_SOFT_RST  = 6'h1F;
  localparam logic [5:0] A_STOR_LO   = 6'h20;
  localparam logic [5:0] A_POWER_CTL = 6'h2D;
  localparam logic [5:0] A_STOR_HI   = 6'h2E;

  localparam int         NSTOR   = 15;
  localparam logic [3:0] PWR_IDX = 4'hD;

  localparam logic [1:0] PWR_MEASURE = 2'b10;
  localparam logic [7:0] SRST_KEY    = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_e;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
  } sample_t;

  function automatic logic [7:0] hi_byte(
    input logic [11:0] s
  );
    return {{4{s[11]}}, s[11:8]};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin,
// with one extra flop for rise/fall strobes.
module spi_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-0 slave emulating the accelerometer register map,
// fed from parallel sample inputs.
module accel_spi_responder
  import accel_spi_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] x_sample,
  input  logic [11:0] y_sample,
  input  logic [11:0] z_sample,
  input  logic        sample_valid,
  output logic        measure_en
);

  logic sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s;

  spi_sync_edge u_sclk (
    .clock  (clock),
    .reset  (reset),
    .d_i    (sclk),
    .q_o    (),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge u_ss (
    .clock  (clock),
    .reset  (reset),
    .d_i    (ss),
    .q_o    (ss_s),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge u_mosi (
    .clock  (clock),
    .reset  (reset),
    .d_i    (mosi),
    .q_o    (mosi_s),
    .rise_o (),
    .fall_o ()
  );

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [6:0]  sh_q;
  logic        rd_q, wr_q;
  logic [5:0]  addr_q;
  logic [7:0]  tx_q;
  logic        oe_q, load_q;
  logic        hit_q, srst_q;
  logic        dready_q;
  sample_t     live_q, snap_q;
  logic [7:0]  stor_q [NSTOR];

  logic [7:0]  rx_byte;
  logic        active, byte_done;
  logic        cmd_done, addr_done, data_done;
  logic [7:0]  rdata;
  logic        in_stor, in_data;

  assign rx_byte   = {sh_q, mosi_s};
  assign active    = (state_q != ST_IDLE) && !ss_s;
  assign byte_done = active && sclk_rise && (cnt_q == 3'd7);
  assign in_stor   = (addr_q >= A_STOR_LO) && (addr_q <= A_STOR_HI);
  assign in_data   = (addr_q >= A_XDATA) && (addr_q <= A_ZH);

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:
          if (ss_fall) state_d = ST_CMD;
        ST_CMD:
          if (byte_done)
            state_d = (rx_byte == CMD_READ ||
                       rx_byte == CMD_WRITE)
                      ? ST_ADDR : ST_IGNORE;
        ST_ADDR:
          if (byte_done) state_d = ST_DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_done   = byte_done && (state_q == ST_CMD);
    addr_done  = byte_done && (state_q == ST_ADDR);
    data_done  = byte_done && (state_q == ST_DATA);
    miso       = oe_q ? tx_q[7] : 1'b0;
    miso_oe    = oe_q;
    measure_en = (stor_q[PWR_IDX][1:0] == PWR_MEASURE);
  end

  // Sample registers are served from the snapshot for coherence.
  always_comb begin
    rdata = 8'h00;
    case (addr_q)
      A_DEVID_AD:  rdata = DEVID_AD;
      A_DEVID_MST: rdata = DEVID_MST;
      A_PARTID:    rdata = PARTID;
      A_XDATA:     rdata = snap_q.x[11:4];
      A_YDATA:     rdata = snap_q.y[11:4];
      A_ZDATA:     rdata = snap_q.z[11:4];
      A_STATUS:    rdata = {7'b0, dready_q};
      A_XL:        rdata = snap_q.x[7:0];
      A_XH:        rdata = hi_byte(snap_q.x);
      A_YL:        rdata = snap_q.y[7:0];
      A_YH:        rdata = hi_byte(snap_q.y);
      A_ZL:        rdata = snap_q.z[7:0];
      A_ZH:        rdata = hi_byte(snap_q.z);
      default:
        if (in_stor) rdata = stor_q[addr_q[3:0]];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      sh_q     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      tx_q     <= '0;
      oe_q     <= 1'b0;
      load_q   <= 1'b0;
      hit_q    <= 1'b0;
      srst_q   <= 1'b0;
      dready_q <= 1'b0;
      live_q   <= '0;
      snap_q   <= '0;
      for (int i = 0; i < NSTOR; i++)
        stor_q[i] <= '0;
    end else begin
      if (!active) begin
        cnt_q <= '0;
        sh_q  <= '0;
      end else if (sclk_rise) begin
        cnt_q <= cnt_q + 3'd1;
        sh_q  <= {sh_q[5:0], mosi_s};
      end

      if (ss_fall) begin
        rd_q   <= 1'b0;
        wr_q   <= 1'b0;
        hit_q  <= 1'b0;
        snap_q <= live_q;
      end else if (cmd_done) begin
        rd_q <= (rx_byte == CMD_READ);
        wr_q <= (rx_byte == CMD_WRITE);
      end

      if (addr_done)
        addr_q <= rx_byte[5:0];
      else if (data_done)
        addr_q <= addr_q + 6'd1;

      // Next read byte is fetched on the fall after its predecessor.
      if (!active) begin
        oe_q   <= 1'b0;
        load_q <= 1'b0;
        tx_q   <= '0;
      end else if ((addr_done || data_done) && rd_q) begin
        load_q <= 1'b1;
      end else if (sclk_fall && load_q) begin
        tx_q   <= rdata;
        oe_q   <= 1'b1;
        load_q <= 1'b0;
      end else if (sclk_fall && oe_q) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end

      if (data_done && rd_q && in_data)
        hit_q <= 1'b1;

      if (data_done && wr_q) begin
        if (in_stor)
          stor_q[addr_q[3:0]] <= rx_byte;
        if (addr_q == A_SOFT_RST && rx_byte == SRST_KEY)
          srst_q <= 1'b1;
      end

      if (ss_rise && srst_q) begin
        srst_q <= 1'b0;
        for (int i = 0; i < NSTOR; i++)
          stor_q[i] <= '0;
      end

      if (sample_valid && measure_en) begin
        live_q   <= '{x: x_sample, y: y_sample, z: z_sample};
        dready_q <= 1'b1;
      end else if (ss_rise && hit_q) begin
        dready_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: SPI master model
// driving register reads/writes against hand-computed values.
module tb_accel_spi_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        miso, miso_oe, measure_en;
  logic [11:0] x_sample = '0;
  logic [11:0] y_sample = '0;
  logic [11:0] z_sample = '0;
  logic        sample_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] rbuf [0:7];

  localparam int HALF = 8;

  always #5 clock = ~clock;

  accel_spi_responder dut (
    .clock        (clock),
    .reset        (reset),
    .sclk         (sclk),
    .mosi         (mosi),
    .ss           (ss),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .x_sample     (x_sample),
    .y_sample     (y_sample),
    .z_sample     (z_sample),
    .sample_valid (sample_valid),
    .measure_en   (measure_en)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bits(input logic [7:0] tx, input int n,
                      output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clock);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clock);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    bits(tx, 8, rx);
  endtask

  task automatic ss_lo();
    @(negedge clock);
    ss = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic ss_hi();
    repeat (HALF) @(negedge clock);
    ss = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic rd(input logic [7:0] a, input int n);
    logic [7:0] d;
    ss_lo();
    xfer(8'h0B, d);
    xfer(a, d);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, d);
      rbuf[i] = d;
    end
    ss_hi();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    logic [7:0] d;
    ss_lo();
    xfer(8'h0A, d);
    xfer(a, d);
    xfer(v, d);
    ss_hi();
  endtask

  task automatic pulse(input logic [11:0] x, input logic [11:0] y,
                       input logic [11:0] z);
    @(negedge clock);
    x_sample = x;
    y_sample = y;
    z_sample = z;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst_miso", {7'b0, miso}, 8'h00);
    chk("rst_oe", {7'b0, miso_oe}, 8'h00);
    chk("rst_meas", {7'b0, measure_en}, 8'h00);

    rd(8'h00, 3);
    chk("id_ad", rbuf[0], 8'hAD);
    chk("id_1d", rbuf[1], 8'h1D);
    chk("id_f2", rbuf[2], 8'hF2);
    chk("oe_idle", {7'b0, miso_oe}, 8'h00);

    rd(8'h2D, 1);
    chk("pwr_rst", rbuf[0], 8'h00);
    wr(8'h2D, 8'h02);
    chk("meas_on", {7'b0, measure_en}, 8'h01);
    rd(8'h2D, 1);
    chk("pwr_rb", rbuf[0], 8'h02);

    rd(8'h0B, 1);
    chk("stat_empty", rbuf[0], 8'h00);
    pulse(12'h7FF, 12'h800, 12'h123);
    rd(8'h0B, 1);
    chk("stat_set", rbuf[0], 8'h01);
    rd(8'h0E, 6);
    chk("xl", rbuf[0], 8'hFF);
    chk("xh", rbuf[1], 8'h07);
    chk("yl", rbuf[2], 8'h00);
    chk("yh", rbuf[3], 8'hF8);
    chk("zl", rbuf[4], 8'h23);
    chk("zh", rbuf[5], 8'h01);
    rd(8'h0B, 1);
    chk("stat_clr_burst", rbuf[0], 8'h00);
    rd(8'h08, 3);
    chk("xdata", rbuf[0], 8'h7F);
    chk("ydata", rbuf[1], 8'h80);
    chk("zdata", rbuf[2], 8'h12);

    pulse(12'h123, 12'h456, 12'h789);
    rd(8'h0B, 1);
    chk("stat_set2", rbuf[0], 8'h01);
    rd(8'h08, 1);
    chk("xdata2", rbuf[0], 8'h12);
    rd(8'h0B, 1);
    chk("stat_clr_08", rbuf[0], 8'h00);

    // sample_valid lands on the cycle the transaction end is seen
    pulse(12'h111, 12'h111, 12'h111);
    ss_lo();
    xfer(8'h0B, d);
    xfer(8'h08, d);
    xfer(8'h00, d);
    chk("xdata3", d, 8'h11);
    repeat (HALF) @(negedge clock);
    ss = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    x_sample = 12'hABC;
    y_sample = 12'h0F0;
    z_sample = 12'hF0F;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    repeat (HALF) @(negedge clock);
    rd(8'h0B, 1);
    chk("stat_race", rbuf[0], 8'h01);

    ss_lo();
    xfer(8'h0B, d);
    xfer(8'h0E, d);
    for (int i = 0; i < 2; i++) begin
      xfer(8'h00, d);
      rbuf[i] = d;
    end
    pulse(12'h111, 12'h222, 12'h333);
    for (int i = 2; i < 6; i++) begin
      xfer(8'h00, d);
      rbuf[i] = d;
    end
    ss_hi();
    chk("coh_xl", rbuf[0], 8'hBC);
    chk("coh_xh", rbuf[1], 8'hFA);
    chk("coh_yl", rbuf[2], 8'hF0);
    chk("coh_yh", rbuf[3], 8'h00);
    chk("coh_zl", rbuf[4], 8'h0F);
    chk("coh_zh", rbuf[5], 8'hFF);
    rd(8'h0E, 2);
    chk("new_xl", rbuf[0], 8'h11);
    chk("new_xh", rbuf[1], 8'h01);

    rd(8'h3F, 2);
    chk("wrap_3f", rbuf[0], 8'h00);
    chk("wrap_00", rbuf[1], 8'hAD);
    rd(8'hC1, 1);
    chk("addr_hi_ign", rbuf[0], 8'h1D);

    wr(8'h2E, 8'h5A);
    rd(8'h2E, 1);
    chk("stor_2e", rbuf[0], 8'h5A);
    wr(8'h10, 8'h77);
    rd(8'h10, 1);
    chk("ro_yl", rbuf[0], 8'h22);

    ss_lo();
    xfer(8'h0A, d);
    xfer(8'h2E, d);
    bits(8'h00, 5, d);
    ss_hi();
    rd(8'h2E, 1);
    chk("partial_wr", rbuf[0], 8'h5A);
    chk("partial_meas", {7'b0, measure_en}, 8'h01);

    wr(8'h1F, 8'h52);
    chk("srst_meas", {7'b0, measure_en}, 8'h00);
    rd(8'h2D, 1);
    chk("srst_2d", rbuf[0], 8'h00);
    rd(8'h2E, 1);
    chk("srst_2e", rbuf[0], 8'h00);
    rd(8'h1F, 1);
    chk("srst_reads0", rbuf[0], 8'h00);
    rd(8'h0E, 1);
    chk("srst_keep", rbuf[0], 8'h11);

    pulse(12'hFFF, 12'hFFF, 12'hFFF);
    rd(8'h0E, 1);
    chk("meas_off_hold", rbuf[0], 8'h11);

    ss_lo();
    xfer(8'h0B, d);
    xfer(8'h0E, d);
    bits(8'h00, 4, d);
    chk("mid_oe", {7'b0, miso_oe}, 8'h01);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_miso", {7'b0, miso}, 8'h00);
    chk("rst_mid_oe", {7'b0, miso_oe}, 8'h00);
    bits(8'hFF, 4, d);
    xfer(8'hFF, d);
    chk("rst_mid_rx", d, 8'h00);
    chk("rst_mid_oe2", {7'b0, miso_oe}, 8'h00);
    ss_hi();
    rd(8'h0E, 1);
    chk("rst_samples", rbuf[0], 8'h00);
    rd(8'h00, 1);
    chk("rst_recover", rbuf[0], 8'hAD);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
